ppu_out_packer: RTL
===================

Name: ppu_out_packer

Overview:
Downstream stage of the PPU. It captures each 16 x INT8 result vector (o_valid/o_data_vec) into a small FIFO, because the PPU has no backpressure. It then serialises the vectors onto a narrower AXI-Stream master with tready backpressure, and asserts tlast once per tile of cfg_vec_count vectors. Dropped vectors set a sticky overflow flag for the controller.

Parameters:
ARRAY_COL, 16, lanes per vector (from params.vh); input width is ARRAY_COL*8.
OUT_W, 64, AXI-Stream tdata width; RATIO = ARRAY_COL*8/OUT_W must be an integer >= 1 (default RATIO 2).
FIFO_DEPTH, 8, vector entries; power of two, >= 2.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
i_start  in  1  1-cycle pulse: flush FIFO, clear counters and overflow, begin a new tile
cfg_vec_count  in  16  vectors per tile; 0 is treated as 1; sampled on i_start
i_valid  in  1  vector strobe from the PPU
i_data_vec  in  ARRAY_COL*8  lane i occupies bits [8i+7:8i]
m_axis_tvalid  out  1  beat valid
m_axis_tdata  out  OUT_W  beat data
m_axis_tlast  out  1  last beat of the tile
m_axis_tready  in  1  sink ready
o_overflow  out  1  sticky: a vector was dropped
o_done  out  1  1-cycle pulse after the tlast beat handshakes
o_busy  out  1  high from i_start until o_done

Behaviour:
- Reset values: tvalid 0, tdata 0, tlast 0, o_overflow 0, o_done 0, o_busy 0. FIFO empty, state IDLE.
- States:
  - IDLE -> SEND on i_start.
  - SEND -> DONE on handshake of the tlast beat.
  - DONE -> IDLE after one cycle; o_done = 1 only in DONE.
- i_start in any state (including mid-tile) does a synchronous flush:
  - ptrs, beat_cnt, vec_cnt reset; o_overflow cleared; vec_total latched; state goes to SEND.
  - An aborted tile produces no tlast and no o_done.
- Write side:
  - Push on i_valid when the FIFO is not full, or when it is full and the last beat of the head vector pops in the same cycle (push-and-pop).
  - Otherwise the vector is dropped and o_overflow is set. It stays set until i_start.
  - i_valid in the same cycle as i_start is pushed into the flushed FIFO.
  - Pushes in IDLE/DONE are accepted and held for the next tile.
- Read side:
  - m_axis_tvalid = (state == SEND) && FIFO not empty.
  - A vector pushed in cycle N can present its first beat in cycle N+1 at the earliest.
  - Beat b (0..RATIO-1) carries bits [OUT_W*b +: OUT_W] of the head vector, lowest bits first.
  - beat_cnt advances on tvalid & tready; the entry pops on the handshake of beat RATIO-1.
  - tdata/tlast must be held stable while tvalid && !tready. tdata = 0 whenever tvalid = 0.
- tlast = tvalid && beat_cnt == RATIO-1 && vec_cnt == vec_total-1.
  - vec_cnt is 16-bit and increments on each pop.
  - After the tlast handshake, any remaining entries wait for the next i_start.
- o_busy = state != IDLE && state != DONE.
- Throughput: one beat per cycle while tready = 1. Sustained input rate must be <= 1 vector per RATIO cycles.

Decomposition:
- params.vh adds OUT_W and PACK_FIFO_DEPTH next to ARRAY_COL. RATIO is derived with a localparam.
- Sub-module: sync_fifo (WIDTH, DEPTH; push, pop, flush, full, empty, head data; first-word visible on the cycle after push, no fall-through).
- The packer owns the FSM, beat/vec counters, serialiser mux and overflow logic.

Test Plan:
1. Reset, i_start with cfg_vec_count=1, one vector of lane i = i (0x0F..0x00 bytes), tready=1:
   - beats 0x0706050403020100, then 0x0F0E0D0C0B0A0908; tlast on beat 2 only; o_done 1 cycle later.
2. cfg_vec_count=3, 3 vectors back-to-back every 2 cycles, tready held 0 for 5 cycles mid-stream:
   - 6 beats in order; tdata/tlast stable during the stall; tlast only on beat 6; o_overflow=0.
3. tready=0, 10 vectors pushed on consecutive cycles:
   - 8 stored, 2 dropped, o_overflow=1; after tready=1, exactly 16 beats are produced.
   - Next i_start clears o_overflow.
4. Full FIFO, tready=1, and i_valid on the cycle the head's last beat pops:
   - the vector is accepted (push-and-pop) and o_overflow stays 0.
5. i_start asserted after beat 3 of a 4-vector tile:
   - tvalid low the next cycle, no tlast, no o_done; the new tile restarts at vec_cnt 0.
6. cfg_vec_count=0, one vector:
   - behaves as a tile of 1; tlast on beat 2.
7. Reset mid-stream:
   - all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/ppu_out_packer_pkg.sv
// rtl/ppu_out_packer_pkg.sv - shared constants, state type and helpers for the PPU output packer
package ppu_out_packer_pkg;

    localparam int DEF_ARRAY_COL   = 16;
    localparam int DEF_OUT_W       = 64;
    localparam int PACK_FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } pack_state_e;

    // Counter width that stays at least one bit when only a single value is needed.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - registered-output-free synchronous FIFO with flush, head visible the cycle after push
module sync_fifo
    import ppu_out_packer_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = cnt_width(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW-1:0]    wr_idx;
    logic [WIDTH-1:0] mem [DEPTH];

    // A push coinciding with a flush lands in slot 0 of the emptied FIFO.
    assign wr_idx = flush ? '0 : wr_ptr[AW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= {{AW{1'b0}}, push};
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_idx] <= wdata;
    end

endmodule

// File: rtl/ppu_out_packer.sv
// rtl/ppu_out_packer.sv - buffers PPU result vectors and serialises them onto an AXI-Stream master per tile
module ppu_out_packer
    import ppu_out_packer_pkg::*;
#(
    parameter int ARRAY_COL  = DEF_ARRAY_COL,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int FIFO_DEPTH = PACK_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic [15:0]            cfg_vec_count,
    input  logic                   i_valid,
    input  logic [ARRAY_COL*8-1:0] i_data_vec,
    output logic                   m_axis_tvalid,
    output logic [OUT_W-1:0]       m_axis_tdata,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic                   o_overflow,
    output logic                   o_done,
    output logic                   o_busy
);

    localparam int VEC_W = ARRAY_COL * 8;
    localparam int RATIO = VEC_W / OUT_W;
    localparam int BW    = cnt_width(RATIO);
    localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

    pack_state_e      state;
    pack_state_e      state_nxt;
    logic [BW-1:0]    beat_cnt;
    logic [15:0]      vec_cnt;
    logic [15:0]      vec_total;
    logic [VEC_W-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             hs;
    logic             last_beat;
    logic             overflow;

    assign last_beat     = (beat_cnt == LAST_BEAT);
    assign m_axis_tvalid = (state == ST_SEND) && !fifo_empty;
    assign hs            = m_axis_tvalid && m_axis_tready;
    assign pop           = hs && last_beat && !i_start;
    // A full FIFO still accepts a vector when the head leaves in the same cycle.
    assign push          = i_valid && (i_start || !fifo_full || pop);

    assign m_axis_tdata  = m_axis_tvalid ? head[OUT_W*beat_cnt +: OUT_W] : '0;
    assign m_axis_tlast  = m_axis_tvalid && last_beat && (vec_cnt == vec_total - 16'd1);
    assign o_overflow    = overflow;
    assign o_done        = (state == ST_DONE);
    assign o_busy        = (state == ST_SEND);

    sync_fifo #(
        .WIDTH (VEC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (i_start),
        .wdata (i_data_vec),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (i_start) begin
            state_nxt = ST_SEND;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_IDLE;
                ST_SEND: if (hs && m_axis_tlast) state_nxt = ST_DONE;
                ST_DONE: state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            vec_cnt   <= '0;
            vec_total <= 16'd1;
            overflow  <= 1'b0;
        end else if (i_start) begin
            beat_cnt  <= '0;
            vec_cnt   <= '0;
            vec_total <= (cfg_vec_count == 16'd0) ? 16'd1 : cfg_vec_count;
            overflow  <= 1'b0;
        end else begin
            if (hs)                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            if (pop)               vec_cnt  <= vec_cnt + 16'd1;
            if (i_valid && !push)  overflow <= 1'b1;
        end
    end

endmodule
